// File: rtl/tx_ds_seq.sv
// Character sequencer feeding the data-strobe transmitter: picks time-code/FCT/N-char/NULL per ready slot.
// Optional time-code insertion is enabled by defining TX_TIMECODE_EN (adds tick_i/time_i ports).
module tx_ds_seq #(
  parameter int unsigned CREDIT_MAX   = 56,
  parameter int unsigned FCT_PEND_MAX = 7
) (
  input  logic       TxClk,
  input  logic       TxReset,
  input  logic       en_null_i,
  input  logic       en_fct_i,
  input  logic       en_data_i,
  input  logic       fct_req_i,
  input  logic       fct_rx_i,
  input  logic       fifo_valid_i,
  input  logic [8:0] fifo_dat_i,
  output logic       fifo_pop_o,
  input  logic       ready_i,
  output logic       valid_o,
  output logic [7:0] dat_o,
  output logic       lchar_o,
  output logic [5:0] credit_o,
  output logic       credit_err_o
`ifdef TX_TIMECODE_EN
  ,
  input  logic       tick_i,
  input  logic [7:0] time_i
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_FOLLOW = 2'd2;

  localparam logic [1:0] C_FCT = 2'b00;
  localparam logic [1:0] C_EOP = 2'b10;
  localparam logic [1:0] C_EEP = 2'b01;
  localparam logic [1:0] C_ESC = 2'b11;

  localparam int unsigned PW = (FCT_PEND_MAX < 2) ? 1 : $clog2(FCT_PEND_MAX + 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(FCT_PEND_MAX);
  localparam logic [6:0]    CRED_MAX = 7'(CREDIT_MAX);

  logic [1:0]    state_q, state_d;
  logic          valid_q, valid_d;
  logic          pop_q, pop_d;
  logic [7:0]    dat_q, dat_d;
  logic          lchar_q, lchar_d;
  logic          fol_pend_q, fol_pend_d;
  logic [7:0]    fol_dat_q, fol_dat_d;
  logic          fol_lchar_q, fol_lchar_d;
  logic [5:0]    credit_q, credit_d;
  logic          err_q, err_d;
  logic [PW-1:0] pend_q, pend_d;

  logic          dec_credit;
  logic          dec_pend;
  logic          inc_pend;
  logic [6:0]    cred_sum;

`ifdef TX_TIMECODE_EN
  logic          tc_pend_q, tc_pend_d;
  logic [7:0]    tc_time_q, tc_time_d;
  logic          tc_clr;
`endif

  // Character selection and output staging; outputs are registered so valid_o lands one cycle after ready_i.
  always_comb begin
    state_d     = state_q;
    valid_d     = 1'b0;
    pop_d       = 1'b0;
    dat_d       = dat_q;
    lchar_d     = lchar_q;
    fol_pend_d  = fol_pend_q;
    fol_dat_d   = fol_dat_q;
    fol_lchar_d = fol_lchar_q;
    dec_credit  = 1'b0;
    dec_pend    = 1'b0;
`ifdef TX_TIMECODE_EN
    tc_clr      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (ready_i) begin
`ifdef TX_TIMECODE_EN
          if (en_data_i && tc_pend_q) begin
            valid_d     = 1'b1;
            dat_d       = {6'b0, C_ESC};
            lchar_d     = 1'b1;
            fol_pend_d  = 1'b1;
            fol_dat_d   = tc_time_q;
            fol_lchar_d = 1'b0;
            tc_clr      = 1'b1;
            state_d     = S_ISSUE;
          end else
`endif
          if (en_fct_i && (pend_q != '0)) begin
            valid_d  = 1'b1;
            dat_d    = {6'b0, C_FCT};
            lchar_d  = 1'b1;
            dec_pend = 1'b1;
            state_d  = S_ISSUE;
          end else if (en_data_i && fifo_valid_i && (credit_q != '0)) begin
            valid_d    = 1'b1;
            pop_d      = 1'b1;
            dec_credit = 1'b1;
            lchar_d    = fifo_dat_i[8];
            dat_d      = fifo_dat_i[8] ? {6'b0, (fifo_dat_i[0] ? C_EEP : C_EOP)}
                                       : fifo_dat_i[7:0];
            state_d    = S_ISSUE;
          end else if (en_null_i) begin
            valid_d     = 1'b1;
            dat_d       = {6'b0, C_ESC};
            lchar_d     = 1'b1;
            fol_pend_d  = 1'b1;
            fol_dat_d   = {6'b0, C_FCT};
            fol_lchar_d = 1'b1;
            state_d     = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        state_d = fol_pend_q ? S_FOLLOW : S_IDLE;
      end
      S_FOLLOW: begin
        // Second half of a pair ignores the enables so the pair is never split.
        if (ready_i) begin
          valid_d    = 1'b1;
          dat_d      = fol_dat_q;
          lchar_d    = fol_lchar_q;
          fol_pend_d = 1'b0;
          state_d    = S_ISSUE;
        end
      end
      default: begin
        state_d    = S_IDLE;
        fol_pend_d = 1'b0;
      end
    endcase
  end

  // Credit: +8 per received FCT, -1 per N-char, clamped with a sticky overflow flag.
  always_comb begin
    cred_sum = {1'b0, credit_q} + (fct_rx_i ? 7'd8 : 7'd0) - (dec_credit ? 7'd1 : 7'd0);
    credit_d = credit_q;
    err_d    = err_q;
    if (cred_sum > CRED_MAX) begin
      credit_d = CRED_MAX[5:0];
      err_d    = 1'b1;
    end else begin
      credit_d = cred_sum[5:0];
    end
  end

  always_comb begin
    inc_pend = fct_req_i && ((pend_q != PEND_MAX) || dec_pend);
    pend_d   = pend_q;
    if (inc_pend && !dec_pend) begin
      pend_d = pend_q + 1'b1;
    end else if (dec_pend && !inc_pend) begin
      pend_d = pend_q - 1'b1;
    end
  end

`ifdef TX_TIMECODE_EN
  always_comb begin
    tc_pend_d = tc_pend_q;
    tc_time_d = tc_time_q;
    if (tick_i) begin
      tc_pend_d = 1'b1;
      tc_time_d = time_i;
    end else if (tc_clr) begin
      tc_pend_d = 1'b0;
    end
  end

  always_ff @(posedge TxClk or posedge TxReset) begin
    if (TxReset) begin
      tc_pend_q <= 1'b0;
      tc_time_q <= '0;
    end else begin
      tc_pend_q <= tc_pend_d;
      tc_time_q <= tc_time_d;
    end
  end
`endif

  always_ff @(posedge TxClk or posedge TxReset) begin
    if (TxReset) begin
      state_q     <= S_IDLE;
      valid_q     <= 1'b0;
      pop_q       <= 1'b0;
      dat_q       <= '0;
      lchar_q     <= 1'b0;
      fol_pend_q  <= 1'b0;
      fol_dat_q   <= '0;
      fol_lchar_q <= 1'b0;
      credit_q    <= '0;
      err_q       <= 1'b0;
      pend_q      <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      pop_q       <= pop_d;
      dat_q       <= dat_d;
      lchar_q     <= lchar_d;
      fol_pend_q  <= fol_pend_d;
      fol_dat_q   <= fol_dat_d;
      fol_lchar_q <= fol_lchar_d;
      credit_q    <= credit_d;
      err_q       <= err_d;
      pend_q      <= pend_d;
    end
  end

  assign valid_o      = valid_q;
  assign fifo_pop_o   = pop_q;
  assign dat_o        = dat_q;
  assign lchar_o      = lchar_q;
  assign credit_o     = credit_q;
  assign credit_err_o = err_q;

endmodule

// File: tb/tb_tx_ds_seq.sv
// Scoreboard bench for tx_ds_seq: expected {pop,lchar,dat} entries are queued with stimulus and checked per valid_o.
`timescale 1ns/1ps
module tb_tx_ds_seq;
  logic       TxClk = 1'b0;
  logic       TxReset;
  logic       en_null_i, en_fct_i, en_data_i;
  logic       fct_req_i, fct_rx_i;
  logic       fifo_valid_i;
  logic [8:0] fifo_dat_i;
  logic       fifo_pop_o;
  logic       ready_i, rdy_en;
  logic       valid_o;
  logic [7:0] dat_o;
  logic       lchar_o;
  logic [5:0] credit_o;
  logic       credit_err_o;
`ifdef TX_TIMECODE_EN
  logic       tick_i;
  logic [7:0] time_i;
`endif

  int total = 0;
  int bad   = 0;
  logic [9:0] sb[$];
  logic [8:0] fq[$];
  logic       prev_valid = 1'b0;

  always #5 TxClk = ~TxClk;

  // Transmitter model: busy while a character is being handed over.
  assign ready_i = rdy_en & ~valid_o;

  tx_ds_seq #(.CREDIT_MAX(56), .FCT_PEND_MAX(7)) dut (
    .TxClk        (TxClk),
    .TxReset      (TxReset),
    .en_null_i    (en_null_i),
    .en_fct_i     (en_fct_i),
    .en_data_i    (en_data_i),
    .fct_req_i    (fct_req_i),
    .fct_rx_i     (fct_rx_i),
    .fifo_valid_i (fifo_valid_i),
    .fifo_dat_i   (fifo_dat_i),
    .fifo_pop_o   (fifo_pop_o),
    .ready_i      (ready_i),
    .valid_o      (valid_o),
    .dat_o        (dat_o),
    .lchar_o      (lchar_o),
    .credit_o     (credit_o),
    .credit_err_o (credit_err_o)
`ifdef TX_TIMECODE_EN
    ,
    .tick_i       (tick_i),
    .time_i       (time_i)
`endif
  );

  always @(posedge TxClk) begin
    if (fifo_pop_o && (fq.size() != 0)) void'(fq.pop_front());
  end

  always @(negedge TxClk) begin
    fifo_valid_i = (fq.size() != 0);
    fifo_dat_i   = (fq.size() != 0) ? fq[0] : 9'h000;
  end

  always @(negedge TxClk) begin
    logic [9:0] e;
    if (fifo_pop_o && !valid_o) begin
      total++; bad++;
      $display("FAIL pop_without_valid: fifo_pop_o=1 while valid_o=0 at %0t", $time);
    end
    if (valid_o) begin
      total++;
      if (prev_valid) begin
        bad++;
        $display("FAIL back_to_back_valid: valid_o high two cycles in a row at %0t", $time);
      end else if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_char: got pop=%0b lchar=%0b dat=%02h, expected no character at %0t",
                 fifo_pop_o, lchar_o, dat_o, $time);
      end else begin
        e = sb.pop_front();
        if ({fifo_pop_o, lchar_o, dat_o} !== e) begin
          bad++;
          $display("FAIL char_seq: got pop=%0b lchar=%0b dat=%02h, expected pop=%0b lchar=%0b dat=%02h at %0t",
                   fifo_pop_o, lchar_o, dat_o, e[9], e[8], e[7:0], $time);
        end
      end
    end
    prev_valid = valid_o;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge TxClk);
      #2;
    end
  endtask

  task automatic do_reset();
    TxReset   = 1'b1;
    en_null_i = 1'b0;
    en_fct_i  = 1'b0;
    en_data_i = 1'b0;
    fct_req_i = 1'b0;
    fct_rx_i  = 1'b0;
    rdy_en    = 1'b1;
`ifdef TX_TIMECODE_EN
    tick_i    = 1'b0;
    time_i    = 8'h00;
`endif
    sb.delete();
    fq.delete();
    tick(2);
    TxReset = 1'b0;
    tick(1);
  endtask

  task automatic wait_sb(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_rx(input int n);
    repeat (n) begin
      fct_rx_i = 1'b1; tick(1);
      fct_rx_i = 1'b0; tick(1);
    end
  endtask

  task automatic pulse_req(input int n);
    repeat (n) begin
      fct_req_i = 1'b1; tick(1);
      fct_req_i = 1'b0; tick(1);
    end
  endtask

  task automatic test_reset();
    TxReset = 1'b1;
    en_null_i = 1'b0; en_fct_i = 1'b0; en_data_i = 1'b0;
    fct_req_i = 1'b0; fct_rx_i = 1'b0; rdy_en = 1'b0;
`ifdef TX_TIMECODE_EN
    tick_i = 1'b0; time_i = 8'h00;
`endif
    tick(2);
    total++;
    if ({valid_o, fifo_pop_o, dat_o, lchar_o, credit_o, credit_err_o} !== 18'h0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%0b pop=%0b dat=%02h lchar=%0b credit=%0d err=%0b, expected all 0",
               valid_o, fifo_pop_o, dat_o, lchar_o, credit_o, credit_err_o);
    end
    TxReset = 1'b0;
    rdy_en  = 1'b1;
    tick(4);
    total++;
    if ({valid_o, credit_o, credit_err_o} !== 8'h0) begin
      bad++;
      $display("FAIL idle_after_reset: got valid=%0b credit=%0d err=%0b, expected 0 0 0",
               valid_o, credit_o, credit_err_o);
    end
  endtask

  task automatic test_null();
    bit ok;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      sb.push_back({1'b0, 1'b1, 8'h03});
      sb.push_back({1'b0, 1'b1, 8'h00});
    end
    en_null_i = 1'b1;
    wait_sb(40, ok);
    en_null_i = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL null_stream_timeout: %0d chars missing, expected 0", sb.size()); end
    tick(6);
    total++;
    if (credit_o !== 6'd0) begin bad++; $display("FAIL null_credit: got %0d expected 0", credit_o); end
    total++;
    if ({lchar_o, dat_o} !== 9'h100) begin
      bad++;
      $display("FAIL null_hold: got lchar=%0b dat=%02h expected lchar=1 dat=00", lchar_o, dat_o);
    end
    // one-cycle latency from ready_i, and a started NULL completes after en_null_i drops
    rdy_en = 1'b0;
    en_null_i = 1'b1;
    tick(3);
    sb.push_back({1'b0, 1'b1, 8'h03});
    sb.push_back({1'b0, 1'b1, 8'h00});
    rdy_en = 1'b1;
    tick(1);
    total++;
    if ({valid_o, lchar_o, dat_o} !== 10'h303) begin
      bad++;
      $display("FAIL ready_latency: got valid=%0b lchar=%0b dat=%02h expected 1 1 03", valid_o, lchar_o, dat_o);
    end
    en_null_i = 1'b0;
    wait_sb(20, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL null_pair_complete: %0d chars missing, expected 0", sb.size()); end
    tick(4);
  endtask

  task automatic test_data();
    bit ok;
    do_reset();
    pulse_rx(2);
    total++;
    if (credit_o !== 6'd16) begin bad++; $display("FAIL data_credit_init: got %0d expected 16", credit_o); end
    fq.push_back(9'h05A); fq.push_back(9'h0A5); fq.push_back(9'h100);
    sb.push_back({1'b1, 1'b0, 8'h5A});
    sb.push_back({1'b1, 1'b0, 8'hA5});
    sb.push_back({1'b1, 1'b1, 8'h02});
    tick(1);
    en_data_i = 1'b1;
    wait_sb(40, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL data_timeout: %0d chars missing, expected 0", sb.size()); end
    tick(3);
    total++;
    if (credit_o !== 6'd13) begin bad++; $display("FAIL data_credit_after: got %0d expected 13", credit_o); end
    fq.push_back(9'h101);
    sb.push_back({1'b1, 1'b1, 8'h01});
    wait_sb(20, ok);
    tick(3);
    total++;
    if (!ok || credit_o !== 6'd12) begin
      bad++;
      $display("FAIL eep_credit: got credit=%0d missing=%0d expected credit=12 missing=0", credit_o, sb.size());
    end
    en_data_i = 1'b0;
  endtask

  task automatic test_credit_zero();
    bit ok;
    do_reset();
    fq.push_back(9'h033);
    tick(1);
    en_data_i = 1'b1;
    en_null_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sb.push_back({1'b0, 1'b1, 8'h03});
      sb.push_back({1'b0, 1'b1, 8'h00});
    end
    wait_sb(40, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL zero_credit_nulls: %0d chars missing, expected 0", sb.size()); end
    // rx credit lands during the selection cycle, so one more NULL precedes the data
    fct_rx_i = 1'b1;
    sb.push_back({1'b0, 1'b1, 8'h03});
    sb.push_back({1'b0, 1'b1, 8'h00});
    sb.push_back({1'b1, 1'b0, 8'h33});
    tick(1);
    fct_rx_i = 1'b0;
    wait_sb(40, ok);
    en_null_i = 1'b0;
    en_data_i = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL zero_credit_release: %0d chars missing, expected 0", sb.size()); end
    tick(4);
    total++;
    if (credit_o !== 6'd7 || fq.size() != 0) begin
      bad++;
      $display("FAIL zero_credit_after: got credit=%0d fifo=%0d expected credit=7 fifo=0", credit_o, fq.size());
    end
  endtask

  task automatic test_fct();
    bit ok;
    do_reset();
    pulse_rx(2);
    fq.push_back(9'h011); fq.push_back(9'h022);
    pulse_req(3);
    for (int i = 0; i < 3; i++) sb.push_back({1'b0, 1'b1, 8'h00});
    sb.push_back({1'b1, 1'b0, 8'h11});
    sb.push_back({1'b1, 1'b0, 8'h22});
    en_fct_i  = 1'b1;
    en_data_i = 1'b1;
    wait_sb(40, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL fct_priority: %0d chars missing, expected 0", sb.size()); end
    tick(4);
    en_fct_i = 1'b0; en_data_i = 1'b0;
    total++;
    if (credit_o !== 6'd14) begin bad++; $display("FAIL fct_credit: got %0d expected 14", credit_o); end
    do_reset();
    pulse_req(8);
    for (int i = 0; i < 7; i++) sb.push_back({1'b0, 1'b1, 8'h00});
    en_fct_i = 1'b1;
    wait_sb(60, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL fct_saturate: %0d chars missing, expected 0", sb.size()); end
    tick(8);
    en_fct_i = 1'b0;
  endtask

  task automatic test_credit_sat();
    bit ok;
    do_reset();
    pulse_rx(7);
    total++;
    if ({credit_err_o, credit_o} !== {1'b0, 6'd56}) begin
      bad++; $display("FAIL credit_full: got credit=%0d err=%0b expected 56 0", credit_o, credit_err_o);
    end
    pulse_rx(1);
    tick(3);
    total++;
    if ({credit_err_o, credit_o} !== {1'b1, 6'd56}) begin
      bad++; $display("FAIL credit_overflow: got credit=%0d err=%0b expected 56 1", credit_o, credit_err_o);
    end
    sb.push_back({1'b0, 1'b1, 8'h03});
    en_null_i = 1'b1;
    wait_sb(20, ok);
    TxReset   = 1'b1;
    en_null_i = 1'b0;
    #1;
    total++;
    if (!ok || {valid_o, fifo_pop_o, dat_o, lchar_o, credit_o, credit_err_o} !== 18'h0) begin
      bad++;
      $display("FAIL mid_pair_reset: got valid=%0b pop=%0b dat=%02h lchar=%0b credit=%0d err=%0b esc_seen=%0b, expected all 0 esc_seen=1",
               valid_o, fifo_pop_o, dat_o, lchar_o, credit_o, credit_err_o, ok);
    end
    tick(2);
    TxReset = 1'b0;
    tick(10);
  endtask

`ifdef TX_TIMECODE_EN
  task automatic test_timecode();
    bit ok;
    do_reset();
    pulse_rx(1);
    fq.push_back(9'h077);
    time_i = 8'h2C;
    tick_i = 1'b1;
    tick(1);
    tick_i = 1'b0;
    time_i = 8'h00;
    sb.push_back({1'b0, 1'b1, 8'h03});
    sb.push_back({1'b0, 1'b0, 8'h2C});
    sb.push_back({1'b1, 1'b0, 8'h77});
    en_data_i = 1'b1;
    wait_sb(40, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL timecode_seq: %0d chars missing, expected 0", sb.size()); end
    tick(4);
    en_data_i = 1'b0;
    total++;
    if (credit_o !== 6'd7) begin bad++; $display("FAIL timecode_credit: got %0d expected 7", credit_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_null();
    test_data();
    test_credit_zero();
    test_fct();
    test_credit_sat();
`ifdef TX_TIMECODE_EN
    test_timecode();
`endif
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL leftover_expected: %0d chars never sent, expected 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tx_ds_seq.md
# tx_ds_seq

Character sequencer directly upstream of the data-strobe character transmitter. Each time the transmitter is ready, it picks the next character to send: a time-code (optional), an FCT, an N-char or EOP/EEP from the transmit FIFO, or a NULL. It presents that character as a one-cycle `valid_o` pulse with `dat_o`/`lchar_o`. It also maintains the flow-control credit counter and the pending-FCT counter.

## Interface
Parameters:
- `CREDIT_MAX`, 56: credit saturation limit in N-chars; must be a multiple of 8.
- `FCT_PEND_MAX`, 7: maximum number of queued FCT requests.

Ports:
- `TxClk`  in  1  clock.
- `TxReset`  in  1  asynchronous, active-high reset.
- `en_null_i`  in  1  link FSM permits NULLs.
- `en_fct_i`  in  1  link FSM permits FCTs.
- `en_data_i`  in  1  link FSM permits N-chars, EOP and EEP.
- `fct_req_i`  in  1  one-cycle pulse; receive buffer freed 8 slots and requests one FCT.
- `fct_rx_i`  in  1  one-cycle pulse; an FCT was received, granting 8 credits.
- `fifo_valid_i`  in  1  transmit FIFO not empty.
- `fifo_dat_i`  in  9  bit 8 is the control flag; if bit 8 = 0, bits [7:0] are data; if bit 8 = 1, bit 0 selects 0 = EOP, 1 = EEP.
- `fifo_pop_o`  out  1  one-cycle pop strobe.
- `ready_i`  in  1  character transmitter ready; this input is low whenever `valid_o` is high.
- `valid_o`  out  1  one-cycle character strobe.
- `dat_o`  out  8  character payload, LSB sent first.
- `lchar_o`  out  1  1 = control code; only `dat_o[1:0]` is meaningful.
- `credit_o`  out  6  current credit count.
- `credit_err_o`  out  1  sticky flag; credit overflow occurred.

## Operation
- Control codes on `dat_o[1:0]`, with `dat_o[7:2]` = 0:
  - FCT = 2'b00
  - EOP = 2'b10
  - EEP = 2'b01
  - ESC = 2'b11
- State machine has three states:
  - IDLE: wait for `ready_i`.
  - ISSUE: `valid_o` = 1 for exactly one cycle, then return to IDLE.
  - FOLLOW: the second half of a NULL or time-code is forced.
- Selection in IDLE with `ready_i` = 1, highest priority first:
  1. Forced follow-up character, if any.
  2. Time-code (see Configuration).
  3. FCT: requires `en_fct_i` and pending > 0.
  4. FIFO entry: requires `en_data_i`, `fifo_valid_i` and credit > 0.
  5. NULL: requires `en_null_i`.
  6. Otherwise nothing; stay in IDLE.
- NULL is ESC followed by FCT.
  - The FCT half does not touch the pending counter.
  - No other character may be inserted between ESC and FCT.
- FIFO character:
  - Assert `fifo_pop_o` in the same cycle as `valid_o`.
  - Decrement credit by 1 for data, EOP and EEP alike.
- Pending FCT counter:
  - Increments on `fct_req_i`, saturating at `FCT_PEND_MAX`; further requests are dropped.
  - Decrements when an FCT is issued.
  - Increment and decrement in the same cycle leave it unchanged.
- Credit counter:
  - Increases by 8 on `fct_rx_i` and decreases by 1 when an N-char is issued; both in the same cycle give a net +7.
  - If the result would exceed `CREDIT_MAX`: clamp to `CREDIT_MAX` and set `credit_err_o`, which stays set until reset.
- Deasserting `en_*` takes effect at the next selection. A NULL or time-code pair already started always completes.
- Reset values:
  - `valid_o` = 0, `fifo_pop_o` = 0, `dat_o` = 0, `lchar_o` = 0.
  - `credit_o` = 0, `credit_err_o` = 0.
  - Pending = 0, state = IDLE, no forced character.
- Reset asserted mid-pair aborts the pair; the follow-up character is never sent.

## Timing
- `ready_i` high in cycle N, with a character selectable: `valid_o`, `dat_o` and `lchar_o` are registered high/valid in cycle N+1 only.
- `fifo_pop_o`, the credit decrement and the pending decrement all take effect at the same edge that raises `valid_o`.
- `valid_o` is never high in two consecutive cycles. After a pulse, the sequencer waits in IDLE until `ready_i` rises again.
- `dat_o` and `lchar_o` hold their last value while `valid_o` = 0.
- Selection uses the counter values registered at cycle N. A `fct_rx_i` pulse in cycle N does not enable data in cycle N+1.

## Configuration
- `TX_TIMECODE_EN` defined:
  - Adds input `tick_i` (1-bit pulse) and input `time_i` (8 bits).
  - A tick latches `time_i` and sets a pending flag; a new tick overwrites a still-pending value.
  - When `en_data_i` = 1, the time-code has top priority after the forced follow-up.
  - The time-code is sent as ESC (`lchar_o` = 1) followed by a forced data character `time_i` (`lchar_o` = 0).
  - Sending a time-code consumes no credit and clears the pending flag.
- `TX_TIMECODE_EN` undefined: no `tick_i` or `time_i` ports, and no time-code logic.

## Test plan
- Reset then `en_null_i` = 1 only, `ready_i` tied high: `valid_o` pulses every other cycle with `lchar_o` = 1 and `dat_o` alternating 0x03, 0x00; `credit_o` = 0 throughout.
- Two `fct_rx_i` pulses, FIFO holding data 0x5A, 0xA5 then EOP, `en_data_i` = 1: characters sent are 0x5A (`lchar_o` = 0), 0xA5, then 0x02 (`lchar_o` = 1); three `fifo_pop_o` pulses; `credit_o` goes 16 → 13.
- Credit 0 with FIFO non-empty and `en_null_i` = 1: only NULLs are sent and `fifo_pop_o` stays 0. After a `fct_rx_i` pulse, the next selection after any in-progress NULL sends the FIFO character.
- Three `fct_req_i` pulses during data flow: three FCTs (`dat_o` = 0x00, `lchar_o` = 1) are sent ahead of FIFO data, then pending = 0. Eight requests in total: exactly 7 FCTs are sent.
- Credit 56 plus a `fct_rx_i` pulse: `credit_o` stays 56 and `credit_err_o` = 1 until `TxReset`. Asserting `TxReset` between the ESC and FCT of a NULL: all outputs read 0 and no FCT follows.
- With `TX_TIMECODE_EN`: `tick_i` with `time_i` = 0x2C while FIFO data is pending: sequence is ESC, then 0x2C (`lchar_o` = 0), then FIFO data; credit is unchanged by the time-code.
